// File: rtl/cpu_trace_capture_pkg.sv
// Shared encodings and default widths for the CPU trace capture block.
package cpu_trace_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_ALL  = 2'd0;
  localparam logic [1:0] MODE_CHG  = 2'd1;
  localparam logic [1:0] MODE_DISP = 2'd2;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_CTRL_W = 16;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_TS_W   = 16;

endpackage

// File: rtl/cpu_trace_capture_ram.sv
// Trace storage: one synchronous write port, one asynchronous read port.
module cpu_trace_capture_ram #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 46,
  parameter int PTR_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [PTR_W-1:0]   waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [PTR_W-1:0]   raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_trace_capture.sv
// Snoops CPU bus/control/address/flags into a timestamped ring buffer,
// stops a programmable number of samples after a masked trigger, then drains.
module cpu_trace_capture
  import cpu_trace_capture_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int TS_W   = DEF_TS_W,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int ENTRY_W = TS_W + CTRL_W + DATA_W + ADDR_W + 2
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               arm,
  input  logic [1:0]         mode,
  input  logic [CTRL_W-1:0]  trig_mask,
  input  logic [CTRL_W-1:0]  trig_value,
  input  logic [PTR_W:0]     post_count,
  input  logic [DATA_W-1:0]  bus,
  input  logic [ADDR_W-1:0]  mem_address_data,
  input  logic [CTRL_W-1:0]  ctrl_state,
  input  logic [DATA_W-1:0]  display_data,
  input  logic               ovf,
  input  logic               zf,
  output logic [1:0]         state,
  output logic               triggered,
  output logic               wrapped,
  output logic [PTR_W:0]     count,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [ENTRY_W-1:0] rd_data
);

  localparam int SNAP_W = ENTRY_W - TS_W;

  state_t             st;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr, remaining, post_clamped;
  logic [PTR_W:0]     cnt;
  logic [TS_W-1:0]    ts;
  logic               first;
  logic [DATA_W-1:0]  disp_prev;
  logic [SNAP_W-1:0]  snap, last_snap;
  logic               capturing, qual, sample, trig_hit, pop;

  assign snap      = {ctrl_state, bus, mem_address_data, ovf, zf};
  assign capturing = (st == ST_ARMED) || (st == ST_POST);
  assign trig_hit  = ((ctrl_state ^ trig_value) & trig_mask) == '0;
  assign pop       = rd_valid && rd_ready;

  // DEPTH is a power of two, so DEPTH-1 is all ones in PTR_W bits.
  assign post_clamped = (post_count > (PTR_W+1)'(DEPTH - 1)) ? '1 : post_count[PTR_W-1:0];

  always_comb begin
    qual = 1'b1;
    case (mode)
      MODE_ALL:  qual = 1'b1;
      MODE_CHG:  qual = first || (snap != last_snap);
      MODE_DISP: qual = display_data != disp_prev;
      default:   qual = 1'b1;
    endcase
  end

  assign sample = capturing && qual;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      st        <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      ts        <= '0;
      remaining <= '0;
      triggered <= 1'b0;
      wrapped   <= 1'b0;
      first     <= 1'b0;
    end else if (arm) begin
      st        <= ST_ARMED;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      ts        <= '0;
      triggered <= 1'b0;
      wrapped   <= 1'b0;
      first     <= 1'b1;
    end else begin
      if (capturing) ts <= ts + 1'b1;
      if (sample) begin
        wr_ptr <= wr_ptr + 1'b1;
        first  <= 1'b0;
        // A full buffer drops its oldest entry to make room.
        if (!cnt[PTR_W]) begin
          cnt <= cnt + 1'b1;
        end else begin
          rd_ptr  <= rd_ptr + 1'b1;
          wrapped <= 1'b1;
        end
        if (st == ST_ARMED && trig_hit) begin
          triggered <= 1'b1;
          remaining <= post_clamped;
          st        <= (post_clamped == '0) ? ST_DONE : ST_POST;
        end else if (st == ST_POST) begin
          remaining <= remaining - 1'b1;
          if (remaining == PTR_W'(1)) st <= ST_DONE;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        cnt    <= cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) disp_prev <= '0;
    else      disp_prev <= display_data;
  end

  // Change-mode reference; the first-sample flag covers its undefined value.
  always_ff @(posedge clk) begin
    if (sample) last_snap <= snap;
  end

  cpu_trace_capture_ram #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W),
    .PTR_W   (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (sample),
    .waddr (wr_ptr),
    .wdata ({ts, snap}),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  assign state    = st;
  assign count    = cnt;
  assign rd_valid = (st == ST_DONE) && (cnt != '0);

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Directed self-checking bench for cpu_trace_capture at default widths.
module tb_cpu_trace_capture;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        arm = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] trig_mask = 16'h0;
  logic [15:0] trig_value = 16'h0;
  logic [4:0]  post_count = 5'd0;
  logic [7:0]  bus = 8'h0;
  logic [3:0]  mem_address_data = 4'h0;
  logic [15:0] ctrl_state = 16'h0;
  logic [7:0]  display_data = 8'h0;
  logic        ovf = 1'b0;
  logic        zf = 1'b0;
  logic [1:0]  state;
  logic        triggered;
  logic        wrapped;
  logic [4:0]  count;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [45:0] rd_data;

  int total = 0;
  int bad = 0;

  cpu_trace_capture dut (
    .clk(clk), .clr(clr), .arm(arm), .mode(mode), .trig_mask(trig_mask),
    .trig_value(trig_value), .post_count(post_count), .bus(bus),
    .mem_address_data(mem_address_data), .ctrl_state(ctrl_state),
    .display_data(display_data), .ovf(ovf), .zf(zf), .state(state),
    .triggered(triggered), .wrapped(wrapped), .count(count),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_arm(input logic [1:0] m, input logic [15:0] msk,
                        input logic [15:0] val, input logic [4:0] post);
    mode = m; trig_mask = msk; trig_value = val; post_count = post;
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    step();
    total++; if (state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid got=%0d exp=0", rd_valid); end
    clr = 1'b1;
    step();
    do_arm(2'd0, 16'h0, 16'h0, 5'd10);
    repeat (3) step();
    total++; if (state !== 2'd2) begin bad++; $display("FAIL rst_pre_post got=%0d exp=2", state); end
    #2 clr = 1'b0;
    #1;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL rst_mid_state got=%0d exp=0", state); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL rst_mid_count got=%0d exp=0", count); end
    total++; if (triggered !== 1'b0) begin bad++; $display("FAIL rst_mid_trig got=%0d exp=0", triggered); end
    total++; if (wrapped !== 1'b0) begin bad++; $display("FAIL rst_mid_wrap got=%0d exp=0", wrapped); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_rdv got=%0d exp=0", rd_valid); end
    step();
    clr = 1'b1;
    step();
    do_arm(2'd0, 16'hFFFF, 16'hFFFF, 5'd0);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL rst_arm_state got=%0d exp=1", state); end
  endtask

  task automatic test_mode_all_wrap();
    ctrl_state = 16'h0000;
    do_arm(2'd0, 16'hFFFF, 16'h1234, 5'd3);
    for (int i = 0; i < 24; i++) begin
      ctrl_state = (i < 20) ? 16'h0000 : (i == 20) ? 16'h1234 : 16'h0001;
      bus = 8'(i); mem_address_data = 4'(i); ovf = i[0]; zf = i[1];
      step();
      if (i == 20) begin
        total++; if (state !== 2'd2) begin bad++; $display("FAIL t2_post got=%0d exp=2", state); end
        total++; if (triggered !== 1'b1) begin bad++; $display("FAIL t2_trig got=%0d exp=1", triggered); end
      end
    end
    total++; if (state !== 2'd3) begin bad++; $display("FAIL t2_done got=%0d exp=3", state); end
    total++; if (count !== 5'd16) begin bad++; $display("FAIL t2_count got=%0d exp=16", count); end
    total++; if (wrapped !== 1'b1) begin bad++; $display("FAIL t2_wrapped got=%0d exp=1", wrapped); end
    rd_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      int s;
      s = 8 + k;
      chk($sformatf("t2_rdv%0d", k), int'(rd_valid), 1);
      chk($sformatf("t2_ts%0d", k), int'(rd_data[45:30]), s);
      chk($sformatf("t2_ctrl%0d", k), int'(rd_data[29:14]),
          (k == 12) ? 32'h1234 : (k > 12) ? 32'h0001 : 32'h0000);
      chk($sformatf("t2_bus%0d", k), int'(rd_data[13:6]), s);
      chk($sformatf("t2_flags%0d", k), int'(rd_data[5:0]), ((s & 15) << 2) | ((s & 1) << 1) | ((s >> 1) & 1));
      step();
    end
    rd_ready = 1'b0;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL t2_empty_rdv got=%0d exp=0", rd_valid); end
    total++; if (state !== 2'd3) begin bad++; $display("FAIL t2_empty_state got=%0d exp=3", state); end
  endtask

  task automatic test_mode_change();
    int exp_ts [6] = '{0, 10, 13, 16, 19, 20};
    int exp_bus [6] = '{'h00, 'h11, 'h22, 'h33, 'h44, 'h55};
    ctrl_state = 16'h0; bus = 8'h00; mem_address_data = 4'h0; ovf = 1'b0; zf = 1'b0;
    do_arm(2'd1, 16'h0, 16'h0, 5'd5);
    repeat (10) step();
    bus = 8'h11; repeat (3) step();
    bus = 8'h22; repeat (3) step();
    bus = 8'h33; repeat (3) step();
    total++; if (count !== 5'd4) begin bad++; $display("FAIL t3_count4 got=%0d exp=4", count); end
    total++; if (state !== 2'd2) begin bad++; $display("FAIL t3_post got=%0d exp=2", state); end
    total++; if (triggered !== 1'b1) begin bad++; $display("FAIL t3_trig got=%0d exp=1", triggered); end
    bus = 8'h44; step();
    bus = 8'h55; step();
    total++; if (state !== 2'd3) begin bad++; $display("FAIL t3_done got=%0d exp=3", state); end
    total++; if (count !== 5'd6) begin bad++; $display("FAIL t3_count6 got=%0d exp=6", count); end
    rd_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t3_ts%0d", k), int'(rd_data[45:30]), exp_ts[k]);
      chk($sformatf("t3_bus%0d", k), int'(rd_data[13:6]), exp_bus[k]);
      step();
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_mode_display();
    logic [7:0] seq [6] = '{8'h00, 8'h05, 8'h05, 8'h0A, 8'h0A, 8'h0F};
    int exp_ts [3] = '{1, 3, 5};
    display_data = 8'h00;
    do_arm(2'd2, 16'h0, 16'h0, 5'd2);
    for (int i = 0; i < 6; i++) begin
      display_data = seq[i];
      step();
    end
    total++; if (state !== 2'd3) begin bad++; $display("FAIL t4_done got=%0d exp=3", state); end
    total++; if (count !== 5'd3) begin bad++; $display("FAIL t4_count got=%0d exp=3", count); end
    rd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t4_ts%0d", k), int'(rd_data[45:30]), exp_ts[k]);
      step();
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_post_zero();
    bus = 8'hA5;
    do_arm(2'd0, 16'h0, 16'h0, 5'd0);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL t5_armed got=%0d exp=1", state); end
    step();
    total++; if (state !== 2'd3) begin bad++; $display("FAIL t5_done got=%0d exp=3", state); end
    total++; if (count !== 5'd1) begin bad++; $display("FAIL t5_count got=%0d exp=1", count); end
    total++; if (triggered !== 1'b1) begin bad++; $display("FAIL t5_trig got=%0d exp=1", triggered); end
    total++; if (rd_data[13:6] !== 8'hA5) begin bad++; $display("FAIL t5_bus got=%0h exp=a5", rd_data[13:6]); end
    total++; if (rd_data[45:30] !== 16'd0) begin bad++; $display("FAIL t5_ts got=%0d exp=0", rd_data[45:30]); end
  endtask

  task automatic test_back_to_back();
    int idx;
    do_arm(2'd0, 16'h0, 16'h0, 5'd7);
    for (int i = 0; i < 8; i++) begin
      bus = 8'(8'h40 + i);
      step();
    end
    total++; if (state !== 2'd3) begin bad++; $display("FAIL t6_done got=%0d exp=3", state); end
    total++; if (count !== 5'd8) begin bad++; $display("FAIL t6_count got=%0d exp=8", count); end
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("t6_bus_c%0d", c), int'(rd_data[13:6]), 'h40 + idx);
      chk($sformatf("t6_cnt_c%0d", c), int'(count), 8 - idx);
      rd_ready = (c % 2 == 0);
      step();
      if (c % 2 == 0) idx++;
    end
    rd_ready = 1'b1;
    arm = 1'b1;
    step();
    arm = 1'b0;
    rd_ready = 1'b0;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL t6_arm_count got=%0d exp=0", count); end
    total++; if (state !== 2'd1) begin bad++; $display("FAIL t6_arm_state got=%0d exp=1", state); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL t6_arm_rdv got=%0d exp=0", rd_valid); end
  endtask

  initial begin
    test_reset();
    test_mode_all_wrap();
    test_mode_change();
    test_mode_display();
    test_post_zero();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
